booth_mult_ctrl: RTL and testbench

- Control FSM for the 12-bit Booth multiplier datapath. It owns the control side of that datapath's interface: it drives dp_rst_n, the load, add/sub and shift strobes, and the operands, and it consumes Q_LSB and Y.
- It puts a valid/ready handshake on both the operand input and the product output.
- It sequences one signed multiply per transaction with fixed latency and holds the product until the consumer accepts it.

---
 rtl/booth_mult_if.sv | 32 +++
 rtl/booth_mult_ctrl.sv | 155 +++++++++++++++
 tb/tb_booth_mult_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_if
//  Description : Operand / product handshake bundle for booth_mult_ctrl.
//                slave  : controller side (accepts operands, offers product)
//                master : producer/consumer side
//  Signals     : in_valid/in_ready/in_a/in_b   operand channel
//                out_valid/out_ready/product   product channel
//  Revision    : 1.0  initial release
// ============================================================================
interface booth_mult_if #(
    parameter int N = 12
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, product
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_ctrl
//  Description : Control FSM for a radix-2 Booth multiplier datapath.
//                One signed N x N multiply per accepted operand pair,
//                fixed latency of 3+2N edges from acceptance to out_valid,
//                product held until the consumer accepts it.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                bus (slave)        operand / product valid-ready handshake
//                o_dp_rst_n         datapath reset, active-low
//                o_dp_A, o_dp_B     captured operands to the datapath
//                o_dp_load_A/B      load M / load LQ and clear Q_1
//                o_dp_load_add      write add/sub result into HQ
//                o_dp_shift         arithmetic right shift of {HQ,LQ,Q_1}
//                o_dp_add_sub       1 = HQ+M, 0 = HQ-M
//                i_dp_Q_LSB         {LQ[0], Q_1}
//                i_dp_Y             {HQ, LQ}
//  Revision    : 1.0  initial release
// ============================================================================
module booth_mult_ctrl #(
    parameter int N  = 12,
    parameter int CW = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    booth_mult_if.slave            bus,
    output logic                   o_dp_rst_n,
    output logic [N-1:0]           o_dp_A,
    output logic [N-1:0]           o_dp_B,
    output logic                   o_dp_load_A,
    output logic                   o_dp_load_B,
    output logic                   o_dp_load_add,
    output logic                   o_dp_shift,
    output logic                   o_dp_add_sub,
    input  wire logic [1:0]        i_dp_Q_LSB,
    input  wire logic [2*N-1:0]    i_dp_Y
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_EVAL  = 3'd3,
        S_SHIFT = 3'd4,
        S_CAPT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CW-1:0] c_LAST_ITER = CW'(N - 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [N-1:0]      r_op_a;
    logic [N-1:0]      r_op_b;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [2*N-1:0]    r_product;
    logic              r_dp_clr;
    logic              r_dp_load;
    logic              r_dp_shift;

    logic              w_accept;
    logic              w_eval;

    assign w_accept = bus.in_valid & r_in_ready;

    // State-only strobes are registered: they are set on the edge that
    // enters their state and cleared on the edge that leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_dp_clr    <= 1'b0;
            r_dp_load   <= 1'b0;
            r_dp_shift  <= 1'b0;
        end else begin
            r_dp_clr   <= 1'b0;
            r_dp_load  <= 1'b0;
            r_dp_shift <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a     <= bus.in_a;
                        r_op_b     <= bus.in_b;
                        r_in_ready <= 1'b0;
                        r_dp_clr   <= 1'b1;
                        r_state    <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_dp_load <= 1'b1;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_dp_shift <= 1'b1;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_CAPT;
                    end else begin
                        r_state <= S_EVAL;
                    end
                end
                S_CAPT: begin
                    r_product   <= i_dp_Y;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The add/sub decision depends on Q_LSB as it stands after the previous
    // shift, which only becomes visible once EVAL is entered, so these two
    // strobes are decoded from the registered state rather than registered.
    assign w_eval        = (r_state == S_EVAL);
    assign o_dp_load_add = w_eval & (i_dp_Q_LSB[1] ^ i_dp_Q_LSB[0]);
    assign o_dp_add_sub  = w_eval & (i_dp_Q_LSB == 2'b01);

    // The datapath is held in reset together with this block as well as
    // during the CLR step of every transaction.
    assign o_dp_rst_n    = ~(rst | r_dp_clr);
    assign o_dp_load_A   = r_dp_load;
    assign o_dp_load_B   = r_dp_load;
    assign o_dp_shift    = r_dp_shift;
    assign o_dp_A        = r_op_a;
    assign o_dp_B        = r_op_b;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult_ctrl
//  Description : Self-checking bench for booth_mult_ctrl with a behavioural
//                Booth datapath attached; products are compared against a
//                plain signed multiply.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_mult_ctrl;
    localparam int N = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    booth_mult_if #(.N(N)) bus ();

    logic            dp_rst_n, dp_load_A, dp_load_B, dp_load_add, dp_shift, dp_add_sub;
    logic [N-1:0]    dp_A, dp_B;
    logic [1:0]      dp_Q_LSB;
    logic [2*N-1:0]  dp_Y;

    booth_mult_ctrl #(.N(N), .CW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .o_dp_rst_n    (dp_rst_n),
        .o_dp_A        (dp_A),
        .o_dp_B        (dp_B),
        .o_dp_load_A   (dp_load_A),
        .o_dp_load_B   (dp_load_B),
        .o_dp_load_add (dp_load_add),
        .o_dp_shift    (dp_shift),
        .o_dp_add_sub  (dp_add_sub),
        .i_dp_Q_LSB    (dp_Q_LSB),
        .i_dp_Y        (dp_Y)
    );

    always #5 clk = ~clk;

    // Behavioural Booth datapath: HQ, LQ, Q_1, M with shift priority.
    logic [N-1:0] m_HQ, m_LQ, m_M;
    logic         m_Q1;
    always @(posedge clk) begin
        if (!dp_rst_n) begin
            m_HQ <= '0; m_LQ <= '0; m_M <= '0; m_Q1 <= 1'b0;
        end else begin
            if (dp_load_A) m_M <= dp_A;
            if (dp_load_B) begin m_LQ <= dp_B; m_Q1 <= 1'b0; end
            if (dp_shift) {m_HQ, m_LQ, m_Q1} <= {m_HQ[N-1], m_HQ, m_LQ};
            else if (dp_load_add) m_HQ <= dp_add_sub ? (m_HQ + m_M) : (m_HQ - m_M);
        end
    end
    assign dp_Q_LSB = {m_LQ[0], m_Q1};
    assign dp_Y     = {m_HQ, m_LQ};

    int vectors = 0;
    int miss    = 0;
    int strobe_viol = 0;

    always @(negedge clk) begin
        if (dp_shift && dp_load_add) strobe_viol++;
        if (dp_add_sub && !dp_load_add) strobe_viol++;
    end

    // Per-edge record of one transaction, indexed by edges after acceptance.
    logic rec_la [0:63];
    logic rec_as [0:63];
    logic rec_sh [0:63];
    logic rec_rn [0:63];
    logic rec_ld [0:63];
    logic rec_ab [0:63];

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    function automatic logic [N-1:0] legal_a();
        logic [N-1:0] a;
        a = N'($urandom);
        while (a == {1'b1, {(N-1){1'b0}}}) a = N'($urandom);
        return a;
    endfunction

    // Stimulus helper: presents one operand pair, waits for out_valid,
    // records strobes per edge. Leaves out_ready low (product held).
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold_valid,
                         output logic [2*N-1:0] prod, output int lat, output bit busy_ready);
        int g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        @(posedge clk);
        lat = 0; busy_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rec_la[i] = 0; rec_as[i] = 0; rec_sh[i] = 0; rec_rn[i] = 1; rec_ld[i] = 0; rec_ab[i] = 1;
        end
        @(negedge clk);
        while (1) begin
            if (lat < 64) begin
                rec_la[lat] = dp_load_add; rec_as[lat] = dp_add_sub; rec_sh[lat] = dp_shift;
                rec_rn[lat] = dp_rst_n;    rec_ld[lat] = dp_load_A & dp_load_B;
                rec_ab[lat] = (dp_A == a) && (dp_B == b);
            end
            if (bus.in_ready) busy_ready = 1'b1;
            bus.in_valid = hold_valid;
            bus.in_a = N'($urandom); bus.in_b = N'($urandom);
            if (bus.out_valid || lat >= 100) break;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        prod = bus.product;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (dp_rst_n !== 1'b0) begin miss++; $display("FAIL reset_dp_rst_n got %b want 0", dp_rst_n); end
        vectors++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.product !== '0) begin miss++; $display("FAIL reset_product got %h want 0", bus.product); end
        vectors++;
        if ({dp_load_A, dp_load_B, dp_load_add, dp_shift, dp_add_sub} !== 5'b0) begin
            miss++; $display("FAIL reset_strobes got %b want 00000", {dp_load_A, dp_load_B, dp_load_add, dp_shift, dp_add_sub});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (dp_rst_n !== 1'b1) begin miss++; $display("FAIL idle_dp_rst_n got %b want 1", dp_rst_n); end
    endtask

    task automatic test_basic();
        logic [2*N-1:0] p; int lat; bit br; bit ab_ok;
        do_op(12'd3, 12'd5, 1'b0, p, lat, br);
        vectors++; if (lat != 2*N+3) begin miss++; $display("FAIL basic_latency got %0d want %0d", lat, 2*N+3); end
        vectors++; if (p !== 24'h00000F) begin miss++; $display("FAIL basic_product got %h want 00000f", p); end
        vectors++; if (br !== 1'b0) begin miss++; $display("FAIL basic_in_ready_busy got 1 want 0"); end
        vectors++; if (rec_rn[0] !== 1'b0) begin miss++; $display("FAIL basic_clr_dp_rst_n got %b want 0", rec_rn[0]); end
        vectors++; if (rec_ld[1] !== 1'b1) begin miss++; $display("FAIL basic_load_strobe got %b want 1", rec_ld[1]); end
        ab_ok = 1'b1;
        for (int i = 0; i <= 2*N+3; i++) ab_ok &= rec_ab[i];
        vectors++; if (ab_ok !== 1'b1) begin miss++; $display("FAIL basic_dp_operands_stable got 0 want 1"); end
        release_out();
        vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miss++; $display("FAIL basic_return_idle got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_booth_decode();
        logic [2*N-1:0] p; int lat; bit br;
        logic [N-1:0] b; logic bprev, exp_la, exp_as;
        logic [2*N+2:0] obs_sh, exp_sh;
        b = 12'd6;
        do_op(12'hFF9, b, 1'b0, p, lat, br);
        vectors++; if (p !== 24'hFFFFD6) begin miss++; $display("FAIL decode_product got %h want ffffd6", p); end
        for (int k = 0; k < N; k++) begin
            bprev  = (k == 0) ? 1'b0 : b[k-1];
            exp_la = b[k] ^ bprev;
            exp_as = ~b[k] & bprev;
            vectors++;
            if (rec_la[2+2*k] !== exp_la || rec_as[2+2*k] !== exp_as) begin
                miss++; $display("FAIL decode_eval%0d got la=%b as=%b want la=%b as=%b",
                                 k, rec_la[2+2*k], rec_as[2+2*k], exp_la, exp_as);
            end
        end
        obs_sh = '0; exp_sh = '0;
        for (int i = 0; i <= 2*N+2; i++) begin
            obs_sh[i] = rec_sh[i];
            exp_sh[i] = (i >= 3) && (i <= 2*N+1) && (i % 2 == 1);
        end
        vectors++; if (obs_sh !== exp_sh) begin miss++; $display("FAIL decode_shift_pattern got %h want %h", obs_sh, exp_sh); end
        release_out();
    endtask

    task automatic test_extremes();
        logic [2*N-1:0] p; int lat; bit br;
        do_op(12'd2047, 12'h800, 1'b0, p, lat, br);
        vectors++; if (p !== 24'hC00800) begin miss++; $display("FAIL ext_max_min got %h want c00800", p); end
        release_out();
        do_op(12'd0, 12'h7FF, 1'b0, p, lat, br);
        vectors++; if (p !== 24'h000000) begin miss++; $display("FAIL ext_zero got %h want 000000", p); end
        vectors++;
        if (rec_la[2] !== 1'b1 || rec_as[2] !== 1'b0 || rec_la[2+2*(N-1)] !== 1'b1 || rec_as[2+2*(N-1)] !== 1'b1) begin
            miss++; $display("FAIL ext_zero_strobes got first=%b%b last=%b%b want first=10 last=11",
                             rec_la[2], rec_as[2], rec_la[2+2*(N-1)], rec_as[2+2*(N-1)]);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [2*N-1:0] p, p2; int lat; bit br; bit held;
        do_op(12'd9, 12'hFF5, 1'b1, p, lat, br);
        vectors++; if (p !== 24'hFFFF9D) begin miss++; $display("FAIL bp_product got %h want ffff9d", p); end
        vectors++; if (br !== 1'b0) begin miss++; $display("FAIL bp_in_ready_busy got 1 want 0"); end
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_a = N'($urandom); bus.in_b = N'($urandom);
            @(posedge clk);
            @(negedge clk);
            held &= (bus.product === 24'hFFFF9D) && (bus.out_valid === 1'b1) && (bus.in_ready === 1'b0);
        end
        vectors++; if (held !== 1'b1) begin miss++; $display("FAIL bp_hold got 0 want 1"); end
        bus.in_valid = 1'b0;
        release_out();
        vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miss++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        do_op(12'd4, 12'hFFD, 1'b0, p2, lat, br);
        vectors++; if (p2 !== 24'hFFFFF4) begin miss++; $display("FAIL bp_next_product got %h want fffff4", p2); end
        release_out();
    endtask

    task automatic test_reset_midop();
        logic [2*N-1:0] p; int lat; bit br;
        @(negedge clk);
        bus.in_a = 12'd100; bus.in_b = 12'd37; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (dp_rst_n !== 1'b0) begin miss++; $display("FAIL rst_mid_dp_rst_n got %b want 0", dp_rst_n); end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== '0 || dp_rst_n !== 1'b0) begin
            miss++; $display("FAIL rst_mid_state got rdy=%b vld=%b prod=%h rstn=%b want 1 0 000000 0",
                             bus.in_ready, bus.out_valid, bus.product, dp_rst_n);
        end
        rst = 1'b0;
        do_op(12'd5, 12'd5, 1'b0, p, lat, br);
        vectors++; if (p !== 24'h000019 || lat != 2*N+3) begin
            miss++; $display("FAIL rst_mid_fresh got %h lat %0d want 000019 lat %0d", p, lat, 2*N+3);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] p, e; int lat; bit br; bit held;
        logic [N-1:0] a, b;
        int stall;
        for (int n = 0; n < 100; n++) begin
            a = legal_a();
            b = N'($urandom);
            e = ref_mul(a, b);
            do_op(a, b, n[0], p, lat, br);
            vectors++;
            if (p !== e || lat != 2*N+3 || br !== 1'b0) begin
                miss++; $display("FAIL b2b_op%0d a=%h b=%h got %h lat %0d want %h lat %0d", n, a, b, p, lat, e, 2*N+3);
            end
            stall = $urandom_range(0, 3);
            held = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                @(negedge clk);
                held &= (bus.out_valid === 1'b1) && (bus.product === e);
            end
            if (stall > 0) begin
                vectors++; if (held !== 1'b1) begin miss++; $display("FAIL b2b_stall%0d got 0 want 1", n); end
            end
            release_out();
        end
        vectors++; if (strobe_viol != 0) begin miss++; $display("FAIL strobe_exclusive got %0d want 0", strobe_viol); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_booth_decode();
        test_extremes();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired vectors=%0d want completion", vectors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
